lcd_text_ctrl: RTL and testbench
================================

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, clock frequency in MHz; every wait is microseconds × CLK_MHZ cycles.
REQ-002 SHALL have parameter E_CYCLES, default 12, width of the LCD_E high pulse in cycles.
REQ-003 SHALL have parameter ENTRY_MODE, default 8'h06, entry-mode byte sent during init.
REQ-004 SHALL have parameter DISPLAY_CTRL, default 8'h0C, display-control byte sent during init.
REQ-005 SHALL have port Clock, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port iValid, input, 1, request strobe.
REQ-008 SHALL have port iRegisterSelect, input, 1, request type: 0 = command, 1 = data.
REQ-009 SHALL have port iData, input, 8, request byte.
REQ-010 SHALL have port oReady, output, 1, controller can accept a request.
REQ-011 SHALL have port oInitDone, output, 1, power-on sequence complete (sticky until reset).
REQ-012 SHALL have port oLCD_Enabled, output, 1, LCD_E.
REQ-013 SHALL have port oLCD_RegisterSelect, output, 1, LCD_RS.
REQ-014 SHALL have port oLCD_ReadWrite, output, 1, tied 0 (write only).
REQ-015 SHALL have port oLCD_StrataFlashControl, output, 1, tied 1.
REQ-016 SHALL have port oLCD_Data, output, 4, SF_D<11:8>.

Function
REQ-017 Each nibble write SHALL be a fixed sequence:
- 2 cycles with data/RS valid and E low (setup);
- E_CYCLES cycles with E high;
- 1 cycle with E low and data held.
REQ-018 Power-on sequence SHALL be, in order:
- wait 15000 µs;
- nibble 0x3, wait 4100 µs;
- nibble 0x3, wait 100 µs;
- nibble 0x3, wait 40 µs;
- nibble 0x2, wait 40 µs.
All with RS = 0.
REQ-019 After REQ-018, the controller SHALL send these bytes with RS = 0, each as a full byte write (REQ-020): 0x28, ENTRY_MODE, DISPLAY_CTRL, 0x01.
REQ-019a After the last byte of REQ-019, it SHALL assert oInitDone and enter IDLE.
REQ-020 A byte write SHALL be:
- high nibble (REQ-017);
- 1 µs gap with E low;
- low nibble;
- execution wait.
REQ-021 The execution wait SHALL be 1640 µs when RS = 0 and byte is 0x01 or 0x02; otherwise 40 µs.
REQ-022 The state machine SHALL have these states:
- PWR_WAIT;
- INIT_NIB / INIT_WAIT, indexed by a 2-bit step counter 0..3;
- CFG, indexed by a 2-bit counter 0..3;
- IDLE;
- HI_NIB;
- GAP;
- LO_NIB;
- EXEC_WAIT.
EXEC_WAIT SHALL return to CFG (next index) during init and to IDLE otherwise.
REQ-023 oReady SHALL be 1 only in IDLE with oInitDone = 1.
REQ-024 A request is accepted on a cycle where iValid = 1 and oReady = 1.
REQ-024a On acceptance, iRegisterSelect and iData SHALL be latched, and oReady SHALL be 0 from the next cycle.
REQ-024b After acceptance, the first setup cycle of the high nibble SHALL be the next cycle.
REQ-025 iValid while oReady = 0 SHALL be ignored; no queueing.
REQ-026 oReady SHALL return to 1 on the cycle after the execution wait expires.
REQ-026a A request presented in that same cycle SHALL be accepted, giving back-to-back writes.
REQ-027 Delay counter SHALL be 32 bits, cleared on every state entry, and SHALL never wrap.
REQ-027a Wait states SHALL exit when count = N − 1, giving exactly N cycles.
REQ-028 oLCD_Data and oLCD_RegisterSelect SHALL be 0 in IDLE and PWR_WAIT, and SHALL otherwise show the current nibble/RS.
REQ-029 oLCD_Enabled SHALL never be high outside the E_CYCLES window.

Reset
REQ-030 While Reset = 0, all of the following SHALL hold, asynchronously:
- state = PWR_WAIT;
- counters = 0;
- oReady = 0, oInitDone = 0, oLCD_Enabled = 0, oLCD_RegisterSelect = 0, oLCD_Data = 0;
- oLCD_ReadWrite = 0, oLCD_StrataFlashControl = 1.
REQ-031 Reset asserted mid-operation, including with E high, SHALL drop E immediately, and the full power-on sequence SHALL restart on release.

Verification (CLK_MHZ = 1, E_CYCLES = 12)
REQ-032 Release reset:
- first E rise at cycle 15002 with oLCD_Data = 0x3;
- E pulses carry nibbles 3, 3, 3, 2, then 2,8, 0,6, 0,C, 0,1;
- oInitDone rises after the 0x01 wait of 1640 cycles.
REQ-033 After init, iValid = 1, RS = 1, iData = 0x41 for one cycle:
- oReady drops;
- E pulses show nibble 0x4 then 0x1 with RS = 1, separated by a gap of ≥ 1 cycle;
- oReady returns 40 cycles after the second E falls, plus the hold cycle.
REQ-034 Command 0x01 → exec wait of 1640 cycles before oReady = 1.
REQ-034a Command 0x80 → exec wait of 40 cycles before oReady = 1.
REQ-035 iValid held high with changing data while busy → only the byte accepted at the oReady edge is written; next byte accepted on the cycle oReady reasserts.
REQ-036 Reset pulsed low while E is high in LO_NIB → E = 0 in the same cycle; oInitDone = 0; the 15000-cycle wait restarts.

Source files
------------

// File: rtl/lcd_text_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_text_ctrl_if
// Request channel between a host and the character-LCD text controller.
//   iValid          host -> ctrl  request strobe
//   iRegisterSelect host -> ctrl  0 = command byte, 1 = data byte
//   iData[7:0]      host -> ctrl  request byte
//   oReady          ctrl -> host  controller accepts a request this cycle
// A request transfers on a cycle where iValid and oReady are both 1.
// ---------------------------------------------------------------------------
interface lcd_text_ctrl_if;
    logic       iValid;
    logic       iRegisterSelect;
    logic [7:0] iData;
    logic       oReady;

    modport master (
        output iValid,
        output iRegisterSelect,
        output iData,
        input  oReady
    );

    modport slave (
        input  iValid,
        input  iRegisterSelect,
        input  iData,
        output oReady
    );
endinterface

// File: rtl/lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_text_ctrl
// Write-only 4-bit-mode driver for an HD44780-style character LCD.
// After reset it runs the power-on sequence (15 ms wait, three 0x3 nibbles,
// one 0x2 nibble) followed by the configuration bytes 0x28, ENTRY_MODE,
// DISPLAY_CTRL and 0x01, then raises oInitDone and accepts host bytes.
//
// Ports
//   Clock                    rising-edge clock
//   Reset                    asynchronous, active-low reset
//   bus (slave)              iValid / iRegisterSelect / iData / oReady
//   oInitDone                power-on sequence finished (sticky)
//   oLCD_Enabled             LCD_E
//   oLCD_RegisterSelect      LCD_RS
//   oLCD_ReadWrite           LCD_RW, always 0
//   oLCD_StrataFlashControl  SF_CE0, always 1 (keeps the shared flash off)
//   oLCD_Data[3:0]           SF_D<11:8>
//
// Every nibble state lasts E_CYCLES+3 cycles: 2 setup, E_CYCLES with E high,
// 1 hold. All delays are microseconds * CLK_MHZ cycles.
// ---------------------------------------------------------------------------
module lcd_text_ctrl #(
    parameter int         CLK_MHZ      = 50,
    parameter int         E_CYCLES     = 12,
    parameter logic [7:0] ENTRY_MODE   = 8'h06,
    parameter logic [7:0] DISPLAY_CTRL = 8'h0C
) (
    input  logic             Clock,
    input  logic             Reset,
    lcd_text_ctrl_if.slave   bus,
    output logic             oInitDone,
    output logic             oLCD_Enabled,
    output logic             oLCD_RegisterSelect,
    output logic             oLCD_ReadWrite,
    output logic             oLCD_StrataFlashControl,
    output logic [3:0]       oLCD_Data
);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        CFG,
        IDLE,
        HI_NIB,
        GAP,
        LO_NIB,
        EXEC_WAIT
    } state_t;

    // Terminal counts: a state that lasts N cycles exits when count == N-1.
    localparam logic [31:0] MHZ          = 32'(CLK_MHZ);
    localparam logic [31:0] PWR_LAST     = 32'd15000 * MHZ - 32'd1;
    localparam logic [31:0] WAIT4100     = 32'd4100  * MHZ - 32'd1;
    localparam logic [31:0] WAIT100      = 32'd100   * MHZ - 32'd1;
    localparam logic [31:0] WAIT40       = 32'd40    * MHZ - 32'd1;
    localparam logic [31:0] WAIT1640     = 32'd1640  * MHZ - 32'd1;
    localparam logic [31:0] GAP_LAST     = MHZ - 32'd1;
    localparam logic [31:0] E_FIRST      = 32'd2;
    localparam logic [31:0] E_LAST       = 32'(E_CYCLES + 1);
    localparam logic [31:0] NIB_LAST     = 32'(E_CYCLES + 2);
    localparam logic [31:0] COUNT_MAX    = 32'hFFFF_FFFF;

    state_t      stateReg, stateNext;
    logic [31:0] countReg;
    logic [1:0]  stepReg;       // power-on nibble index 0..3
    logic [1:0]  cfgIdxReg;     // configuration byte index 0..3
    logic [7:0]  byteReg;       // byte currently being written
    logic        rsReg;         // RS of byte currently being written
    logic        initDoneReg;

    logic        accept;
    logic        leaving;
    logic [31:0] initWaitLast;
    logic [31:0] execLast;
    logic [7:0]  cfgByte;
    logic [3:0]  initNibble;
    logic        eWindow;

    assign accept  = bus.iValid && bus.oReady;
    assign leaving = (stateNext != stateReg);

    // Per-step lookups
    always_comb begin
        initWaitLast = WAIT40;
        case (stepReg)
            2'd0:    initWaitLast = WAIT4100;
            2'd1:    initWaitLast = WAIT100;
            default: initWaitLast = WAIT40;
        endcase
    end

    always_comb begin
        cfgByte = 8'h28;
        case (cfgIdxReg)
            2'd0:    cfgByte = 8'h28;
            2'd1:    cfgByte = ENTRY_MODE;
            2'd2:    cfgByte = DISPLAY_CTRL;
            default: cfgByte = 8'h01;
        endcase
    end

    // Clear-display and return-home commands need the long execution time.
    assign execLast   = (!rsReg && (byteReg == 8'h01 || byteReg == 8'h02)) ? WAIT1640 : WAIT40;
    assign initNibble = (stepReg == 2'd3) ? 4'h2 : 4'h3;

    // State register and datapath
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg    <= PWR_WAIT;
            countReg    <= '0;
            stepReg     <= '0;
            cfgIdxReg   <= '0;
            byteReg     <= '0;
            rsReg       <= 1'b0;
            initDoneReg <= 1'b0;
        end else begin
            stateReg <= stateNext;

            // Restart on every state entry; saturate rather than wrap.
            if (leaving)
                countReg <= '0;
            else if (countReg != COUNT_MAX)
                countReg <= countReg + 32'd1;

            if (stateReg == INIT_WAIT && leaving)
                stepReg <= stepReg + 2'd1;

            if (stateReg == CFG) begin
                byteReg <= cfgByte;
                rsReg   <= 1'b0;
            end

            if (accept) begin
                byteReg <= bus.iData;
                rsReg   <= bus.iRegisterSelect;
            end

            if (stateReg == EXEC_WAIT && leaving && !initDoneReg) begin
                if (cfgIdxReg == 2'd3)
                    initDoneReg <= 1'b1;
                else
                    cfgIdxReg <= cfgIdxReg + 2'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            PWR_WAIT:  if (countReg == PWR_LAST)     stateNext = INIT_NIB;
            INIT_NIB:  if (countReg == NIB_LAST)     stateNext = INIT_WAIT;
            INIT_WAIT: if (countReg == initWaitLast) stateNext = (stepReg == 2'd3) ? CFG : INIT_NIB;
            CFG:                                     stateNext = HI_NIB;
            IDLE:      if (accept)                   stateNext = HI_NIB;
            HI_NIB:    if (countReg == NIB_LAST)     stateNext = GAP;
            GAP:       if (countReg == GAP_LAST)     stateNext = LO_NIB;
            LO_NIB:    if (countReg == NIB_LAST)     stateNext = EXEC_WAIT;
            EXEC_WAIT: begin
                if (countReg == execLast) begin
                    // Last configuration byte hands over to IDLE as well.
                    if (initDoneReg || cfgIdxReg == 2'd3)
                        stateNext = IDLE;
                    else
                        stateNext = CFG;
                end
            end
            default:                                 stateNext = PWR_WAIT;
        endcase
    end

    // Outputs (decoded from registered state, so reset clears them at once)
    assign eWindow = (countReg >= E_FIRST) && (countReg <= E_LAST);

    always_comb begin
        oLCD_Enabled        = 1'b0;
        oLCD_RegisterSelect = 1'b0;
        oLCD_Data           = 4'h0;
        case (stateReg)
            INIT_NIB: begin
                oLCD_Data    = initNibble;
                oLCD_Enabled = eWindow;
            end
            INIT_WAIT: oLCD_Data = initNibble;
            CFG:       oLCD_Data = cfgByte[7:4];
            HI_NIB: begin
                oLCD_Data           = byteReg[7:4];
                oLCD_RegisterSelect = rsReg;
                oLCD_Enabled        = eWindow;
            end
            GAP: begin
                oLCD_Data           = byteReg[7:4];
                oLCD_RegisterSelect = rsReg;
            end
            LO_NIB: begin
                oLCD_Data           = byteReg[3:0];
                oLCD_RegisterSelect = rsReg;
                oLCD_Enabled        = eWindow;
            end
            EXEC_WAIT: begin
                oLCD_Data           = byteReg[3:0];
                oLCD_RegisterSelect = rsReg;
            end
            default: ;
        endcase
    end

    assign bus.oReady              = (stateReg == IDLE) && initDoneReg;
    assign oInitDone               = initDoneReg;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_ctrl
// Directed bench for lcd_text_ctrl with CLK_MHZ = 1, E_CYCLES = 12.
// Cycle numbers are counted from reset release: cycle k is the state after
// the k-th rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_text_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       oInitDone;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    lcd_text_ctrl_if bus ();

    lcd_text_ctrl #(
        .CLK_MHZ      (1),
        .E_CYCLES     (12),
        .ENTRY_MODE   (8'h06),
        .DISPLAY_CTRL (8'h0C)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .bus                     (bus),
        .oInitDone               (oInitDone),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_Data               (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    int cyc  = 0;
    int rel0 = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Hard stop in case the sequence ever stalls
    initial begin
        #(100000 * 10);
        $display("FAIL global_timeout: observed no finish, expected finish before 100000 cycles");
        $fatal(1);
    end

    function automatic int now();
        return cyc - rel0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("vec %0d @%0d %s: observed 0x%0h expected 0x%0h", vectors, now(), tag, obs, exp);
    endtask

    // Wait (bounded) for the next E pulse; report rise cycle, nibble, RS and width.
    // Returns on the first falling-edge sample with E low again.
    task automatic getPulse(input int limit, output int rise, output int nib,
                            output int rs, output int width);
        rise = -1; nib = -1; rs = -1; width = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clock);
            if (oLCD_Enabled) begin
                rise = now();
                nib  = int'(oLCD_Data);
                rs   = int'(oLCD_RegisterSelect);
                while (oLCD_Enabled && width < 100) begin
                    width++;
                    @(negedge Clock);
                end
                return;
            end
        end
    endtask

    task automatic waitReady(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clock);
            if (bus.oReady) begin
                at = now();
                return;
            end
        end
    endtask

    // Present one byte at a falling edge where oReady = 1 and follow it through.
    task automatic sendByte(input string tag, input logic rsIn, input logic [7:0] d,
                            input int readyDelay);
        int t0, rise, nib, rs, width, fall1, r;
        bus.iValid          = 1'b1;
        bus.iRegisterSelect = rsIn;
        bus.iData           = d;
        t0 = now();
        @(negedge Clock);
        bus.iValid = 1'b0;
        check({tag, "_ready_drop"}, 32'(bus.oReady), 32'd0);
        getPulse(100, rise, nib, rs, width);
        check({tag, "_hi_nib"},   32'(nib),  32'(d[7:4]));
        check({tag, "_hi_rs"},    32'(rs),   32'(rsIn));
        check({tag, "_hi_rise"},  32'(rise), 32'(t0 + 3));
        check({tag, "_hi_width"}, 32'(width), 32'd12);
        fall1 = rise + width;
        getPulse(100, rise, nib, rs, width);
        check({tag, "_lo_nib"},   32'(nib),  32'(d[3:0]));
        check({tag, "_lo_rs"},    32'(rs),   32'(rsIn));
        check({tag, "_gap_ge1"},  32'((rise - fall1) >= 1), 32'd1);
        check({tag, "_lo_width"}, 32'(width), 32'd12);
        waitReady(3000, r);
        check({tag, "_ready_at"}, 32'(r), 32'(t0 + readyDelay));
        check({tag, "_idle_data"}, 32'(oLCD_Data), 32'd0);
    endtask

    int expNib [12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
    int expRise[12] = '{15002, 19117, 19232, 19287, 19343, 19359,
                        19415, 19431, 19487, 19503, 19559, 19575};

    initial begin
        int rise, nib, rs, width, t0, t1, tR, nr, r;
        int recNib[4];
        int recRs[4];
        logic prevE;

        bus.iValid          = 1'b0;
        bus.iRegisterSelect = 1'b0;
        bus.iData           = 8'h00;

        // Held in reset
        repeat (3) @(negedge Clock);
        check("rst_ready",   32'(bus.oReady),               32'd0);
        check("rst_initdone",32'(oInitDone),                32'd0);
        check("rst_e",       32'(oLCD_Enabled),             32'd0);
        check("rst_rs",      32'(oLCD_RegisterSelect),      32'd0);
        check("rst_data",    32'(oLCD_Data),                32'd0);
        check("rst_rw",      32'(oLCD_ReadWrite),           32'd0);
        check("rst_sf",      32'(oLCD_StrataFlashControl),  32'd1);

        // Power-on sequence and configuration bytes
        Reset = 1'b1;
        rel0  = cyc;
        for (int i = 0; i < 12; i++) begin
            getPulse(16000, rise, nib, rs, width);
            check($sformatf("init%0d_nib", i),   32'(nib),   32'(expNib[i]));
            check($sformatf("init%0d_rise", i),  32'(rise),  32'(expRise[i]));
            check($sformatf("init%0d_rs", i),    32'(rs),    32'd0);
            check($sformatf("init%0d_width", i), 32'(width), 32'd12);
        end
        while (now() < 21227) @(negedge Clock);
        check("initdone_early", 32'(oInitDone), 32'd0);
        check("ready_early",    32'(bus.oReady), 32'd0);
        @(negedge Clock);
        check("initdone_set",   32'(oInitDone), 32'd1);
        check("ready_set",      32'(bus.oReady), 32'd1);

        // Data byte, long command, short command
        sendByte("data41", 1'b1, 8'h41, 72);
        sendByte("cmd01",  1'b0, 8'h01, 1672);
        sendByte("cmd80",  1'b0, 8'h80, 72);

        // iValid held high with changing data while busy
        bus.iValid          = 1'b1;
        bus.iRegisterSelect = 1'b1;
        bus.iData           = 8'hA5;
        t0 = now();
        nr = 0; tR = -1; prevE = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            if (oLCD_Enabled && !prevE && nr < 4) begin
                recNib[nr] = int'(oLCD_Data);
                recRs[nr]  = int'(oLCD_RegisterSelect);
                nr++;
            end
            prevE = oLCD_Enabled;
            if (bus.oReady) begin
                tR = now();
                break;
            end
            bus.iData           = 8'(i * 37 + 11);
            bus.iRegisterSelect = 1'(i);
        end
        check("busy_pulses",   32'(nr),        32'd2);
        check("busy_hi_nib",   32'(recNib[0]), 32'hA);
        check("busy_lo_nib",   32'(recNib[1]), 32'h5);
        check("busy_hi_rs",    32'(recRs[0]),  32'd1);
        check("busy_lo_rs",    32'(recRs[1]),  32'd1);
        check("busy_ready_at", 32'(tR),        32'(t0 + 72));
        bus.iData           = 8'h3C;
        bus.iRegisterSelect = 1'b1;
        t1 = now();
        @(negedge Clock);
        bus.iValid = 1'b0;
        check("b2b_ready_drop", 32'(bus.oReady), 32'd0);
        getPulse(100, rise, nib, rs, width);
        check("b2b_hi_nib",  32'(nib),  32'h3);
        check("b2b_hi_rise", 32'(rise), 32'(t1 + 3));
        getPulse(100, rise, nib, rs, width);
        check("b2b_lo_nib",  32'(nib),  32'hC);
        waitReady(3000, r);
        check("b2b_ready_at", 32'(r), 32'(t1 + 72));

        // Reset while E is high in the low nibble
        bus.iValid          = 1'b1;
        bus.iRegisterSelect = 1'b1;
        bus.iData           = 8'h77;
        t0 = now();
        @(negedge Clock);
        bus.iValid = 1'b0;
        while (now() < t0 + 22) @(negedge Clock);
        check("pre_rst_e", 32'(oLCD_Enabled), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_e",        32'(oLCD_Enabled), 32'd0);
        check("mid_rst_initdone", 32'(oInitDone),    32'd0);
        check("mid_rst_ready",    32'(bus.oReady),   32'd0);
        check("mid_rst_data",     32'(oLCD_Data),    32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        rel0  = cyc;
        getPulse(16000, rise, nib, rs, width);
        check("restart_rise", 32'(rise), 32'd15002);
        check("restart_nib",  32'(nib),  32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
